// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the memory port arbiter.
//   - FSM state encoding (2-bit localparams)
//   - default address/data widths
//   - run counter width
package ctrl_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 8;

  // Width of the consecutive-data-grant counter; MAX_DATA_RUN fits in it.
  localparam int RUN_W = 3;

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_FETCH      = 2'd1;
  localparam logic [1:0] ST_DATA       = 2'd2;
  localparam logic [1:0] ST_FETCH_DROP = 2'd3;

endpackage

// File: rtl/arb_run_counter.sv
// arb_run_counter: saturating count of data grants issued while a fetch is
// waiting, plus the "limit reached" compare used to force a fetch grant.
// Ports:
//   clock, reset  - clock, async active-low reset
//   inc           - a data grant was issued while fetch was pending
//   clr           - restart the run (fetch granted, or data with no fetch pending)
//   run           - current count
//   limit_reached - run >= MAX_DATA_RUN
module arb_run_counter
  import ctrl_pkg::*;
#(
  parameter int MAX_DATA_RUN = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [RUN_W-1:0] run,
  output logic             limit_reached
);

  localparam logic [RUN_W-1:0] MAX_RUN = RUN_W'(MAX_DATA_RUN);
  localparam logic [RUN_W-1:0] SAT_VAL = {RUN_W{1'b1}};

  logic [RUN_W-1:0] run_d, run_q;

  always_comb begin
    run_d = run_q;
    if (clr) begin
      run_d = '0;
    end else if (inc && (run_q != SAT_VAL)) begin
      run_d = run_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      run_q <= '0;
    end else begin
      run_q <= run_d;
    end
  end

  assign run           = run_q;
  assign limit_reached = (run_q >= MAX_RUN);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the fetch stage
// and the exec (load/store) stage, one multi-cycle transaction at a time.
// Ports:
//   clock, reset              - clock, async active-low reset
//   fetch_req/addr, flush     - instruction read request, branch flush
//   fetch_ack/rdata           - fetch completion pulse and registered byte
//   data_req/we/addr/wdata    - load/store request
//   data_ack/rdata            - data completion pulse and registered load data
//   mem_req/we/addr/wdata     - registered memory command
//   mem_rdata, mem_ack        - memory read data and completion pulse
//   stall_fetch               - fetch_req & ~fetch_ack
//   busy                      - registered, a transaction is in progress
//   dbg_state                 - current FSM state
//
// Handshake: requesters hold *_req (and stable operands) until their *_ack
// pulse; the ack is a one-cycle pulse one cycle after mem_ack. Memory holds
// no obligation beyond a single-cycle mem_ack while mem_req is high; mem_ack
// with mem_req low is ignored.
module mem_port_arbiter
  import ctrl_pkg::*;
#(
  parameter int AW           = AW_DEF,
  parameter int DW           = DW_DEF,
  parameter int MAX_DATA_RUN = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          fetch_req,
  input  logic [AW-1:0] fetch_addr,
  input  logic          flush,
  output logic          fetch_ack,
  output logic [DW-1:0] fetch_rdata,
  input  logic          data_req,
  input  logic          data_we,
  input  logic [AW-1:0] data_addr,
  input  logic [DW-1:0] data_wdata,
  output logic          data_ack,
  output logic [DW-1:0] data_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          stall_fetch,
  output logic          busy,
  output logic [1:0]    dbg_state
);

  logic [1:0]    state_d, state_q;
  logic          mem_req_d, mem_req_q;
  logic          mem_we_d, mem_we_q;
  logic [AW-1:0] mem_addr_d, mem_addr_q;
  logic [DW-1:0] mem_wdata_d, mem_wdata_q;
  logic          fetch_ack_d, fetch_ack_q;
  logic          data_ack_d, data_ack_q;
  logic [DW-1:0] fetch_rdata_d, fetch_rdata_q;
  logic [DW-1:0] data_rdata_d, data_rdata_q;
  logic          busy_d, busy_q;

  logic             run_inc, run_clr, run_limit;
  logic [RUN_W-1:0] run_cnt;

  // A requester being acked this cycle still has its req high; masking it
  // prevents granting the same request twice. Flush kills the fetch request
  // for the cycle since its address is stale.
  logic fetch_req_eff, data_req_eff, grant_data, grant_fetch;

  assign fetch_req_eff = fetch_req & ~fetch_ack_q & ~flush;
  assign data_req_eff  = data_req & ~data_ack_q;
  // Data wins unless fetch has already waited MAX_DATA_RUN data grants.
  assign grant_data    = data_req_eff & (~fetch_req_eff | ~run_limit);
  assign grant_fetch   = ~grant_data & fetch_req_eff;

  arb_run_counter #(
    .MAX_DATA_RUN (MAX_DATA_RUN)
  ) u_run_counter (
    .clock         (clock),
    .reset         (reset),
    .inc           (run_inc),
    .clr           (run_clr),
    .run           (run_cnt),
    .limit_reached (run_limit)
  );

  always_comb begin
    state_d       = state_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    fetch_ack_d   = 1'b0;
    data_ack_d    = 1'b0;
    fetch_rdata_d = fetch_rdata_q;
    data_rdata_d  = data_rdata_q;
    run_inc       = 1'b0;
    run_clr       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (grant_data) begin
          state_d     = ST_DATA;
          mem_req_d   = 1'b1;
          mem_we_d    = data_we;
          mem_addr_d  = data_addr;
          mem_wdata_d = data_wdata;
          run_inc     = fetch_req_eff;
          run_clr     = ~fetch_req_eff;
        end else if (grant_fetch) begin
          state_d     = ST_FETCH;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = fetch_addr;
          mem_wdata_d = '0;
          run_clr     = 1'b1;
        end
      end
      ST_FETCH: begin
        if (mem_ack) begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
          // A flush arriving with the data discards the instruction.
          if (!flush) begin
            fetch_ack_d   = 1'b1;
            fetch_rdata_d = mem_rdata;
          end
        end else if (flush) begin
          state_d = ST_FETCH_DROP;
        end
      end
      ST_DATA: begin
        if (mem_ack) begin
          state_d      = ST_IDLE;
          mem_req_d    = 1'b0;
          data_ack_d   = 1'b1;
          data_rdata_d = mem_rdata;
        end
      end
      ST_FETCH_DROP: begin
        // Memory must still finish the cancelled read; its data is thrown away.
        if (mem_ack) begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      fetch_ack_q   <= 1'b0;
      data_ack_q    <= 1'b0;
      fetch_rdata_q <= '0;
      data_rdata_q  <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      fetch_ack_q   <= fetch_ack_d;
      data_ack_q    <= data_ack_d;
      fetch_rdata_q <= fetch_rdata_d;
      data_rdata_q  <= data_rdata_d;
      busy_q        <= busy_d;
    end
  end

  assign fetch_ack   = fetch_ack_q;
  assign fetch_rdata = fetch_rdata_q;
  assign data_ack    = data_ack_q;
  assign data_rdata  = data_rdata_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign busy        = busy_q;
  assign stall_fetch = fetch_req & ~fetch_ack_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized traffic, checked
// against a transaction-level reference model kept in this file.
module tb_mem_port_arbiter;

  localparam int AW   = 8;
  localparam int DW   = 8;
  localparam int MAXR = 3;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic          fetch_req = 1'b0, flush = 1'b0;
  logic [AW-1:0] fetch_addr = '0;
  logic          data_req = 1'b0, data_we = 1'b0;
  logic [AW-1:0] data_addr = '0;
  logic [DW-1:0] data_wdata = '0;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack = 1'b0;

  logic          fetch_ack, data_ack, mem_req, mem_we, stall_fetch, busy;
  logic [DW-1:0] fetch_rdata, data_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [1:0]    dbg_state;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_DATA_RUN(MAXR)) dut (
    .clock       (clock),
    .reset       (reset),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .flush       (flush),
    .fetch_ack   (fetch_ack),
    .fetch_rdata (fetch_rdata),
    .data_req    (data_req),
    .data_we     (data_we),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .data_ack    (data_ack),
    .data_rdata  (data_rdata),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .stall_fetch (stall_fetch),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard / counters ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [DW:0] exp_q[$];   // {is_fetch, rdata} for each expected ack

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // One transaction in flight at most; "dropped" marks a flushed fetch.
  bit            m_busy, m_is_fetch, m_dropped;
  int            m_run;
  logic          e_fetch_ack, e_data_ack, e_mem_req, e_mem_we;
  logic [AW-1:0] e_mem_addr;
  logic [DW-1:0] e_mem_wdata, e_fetch_rdata, e_data_rdata;

  function automatic void model_reset();
    m_busy = 0; m_is_fetch = 0; m_dropped = 0; m_run = 0;
    e_fetch_ack = 0; e_data_ack = 0; e_mem_req = 0; e_mem_we = 0;
    e_mem_addr = '0; e_mem_wdata = '0; e_fetch_rdata = '0; e_data_rdata = '0;
    exp_q.delete();
  endfunction

  function automatic void model_update();
    logic fa, da;
    bit f, d;
    fa = e_fetch_ack;
    da = e_data_ack;
    e_fetch_ack = 0;
    e_data_ack  = 0;
    if (!reset) begin
      model_reset();
      return;
    end
    if (!m_busy) begin
      f = fetch_req && !fa && !flush;
      d = data_req && !da;
      if (d && (!f || m_run < MAXR)) begin
        m_busy = 1; m_is_fetch = 0; m_dropped = 0;
        m_run = f ? ((m_run < 7) ? m_run + 1 : 7) : 0;
        e_mem_req = 1; e_mem_we = data_we; e_mem_addr = data_addr; e_mem_wdata = data_wdata;
      end else if (f) begin
        m_busy = 1; m_is_fetch = 1; m_dropped = 0; m_run = 0;
        e_mem_req = 1; e_mem_we = 0; e_mem_addr = fetch_addr; e_mem_wdata = '0;
      end
    end else if (mem_ack) begin
      m_busy = 0;
      e_mem_req = 0;
      if (!m_is_fetch) begin
        e_data_ack = 1; e_data_rdata = mem_rdata;
        exp_q.push_back({1'b0, mem_rdata});
      end else if (!m_dropped && !flush) begin
        e_fetch_ack = 1; e_fetch_rdata = mem_rdata;
        exp_q.push_back({1'b1, mem_rdata});
      end
    end else if (m_is_fetch && flush) begin
      m_dropped = 1;
    end
  endfunction

  // ---------------- memory responder ----------------
  int          fix_wait = -1;     // <0: random 0..2 wait states
  bit          use_fix_rd = 0;
  logic [DW-1:0] fix_rd = '0;
  bit          in_txn = 0;
  int          wait_left = 0;

  task automatic mem_drive();
    if (e_mem_req) begin
      if (!in_txn) begin
        in_txn = 1;
        wait_left = (fix_wait >= 0) ? fix_wait : $urandom_range(0, 2);
      end
      if (wait_left == 0) begin
        mem_ack = 1'b1;
        mem_rdata = use_fix_rd ? fix_rd : DW'($urandom);
        in_txn = 0;
      end else begin
        wait_left--;
        mem_ack = 1'b0;
        mem_rdata = DW'($urandom);
      end
    end else begin
      // Stray acks while idle must be ignored.
      mem_ack = ($urandom_range(0, 7) == 0);
      mem_rdata = DW'($urandom);
    end
  endtask

  // ---------------- per-cycle driver / checker ----------------
  task automatic check_outputs();
    logic [DW:0] e;
    chk("fetch_ack", fetch_ack, e_fetch_ack);
    chk("data_ack", data_ack, e_data_ack);
    chk("ack_overlap", fetch_ack & data_ack, 1'b0);
    chk("mem_req", mem_req, e_mem_req);
    chk("busy", busy, m_busy);
    chk("fetch_rdata", fetch_rdata, e_fetch_rdata);
    chk("data_rdata", data_rdata, e_data_rdata);
    if (e_mem_req) begin
      chk("mem_we", mem_we, e_mem_we);
      chk("mem_addr", mem_addr, e_mem_addr);
      chk("mem_wdata", mem_wdata, e_mem_wdata);
    end
    if (fetch_ack) begin
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_fetch", {1'b1, fetch_rdata}, e);
      end else chk("sb_unexpected_fetch_ack", fetch_ack, 1'b0);
    end
    if (data_ack) begin
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_data", {1'b0, data_rdata}, e);
      end else chk("sb_unexpected_data_ack", data_ack, 1'b0);
    end
  endtask

  // Called just after a falling edge with this cycle's inputs applied.
  task automatic tick();
    #1;
    chk("stall_fetch", stall_fetch, fetch_req & ~e_fetch_ack);
    mem_drive();
    @(posedge clock);
    model_update();
    @(negedge clock);
    check_outputs();
  endtask

  task automatic wait_fetch_ack(input string tag, output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (!fetch_ack && cycles < 20);
    if (!fetch_ack) chk({tag, "_timeout"}, cycles, 0);
  endtask

  task automatic random_inputs();
    if (!fetch_req || e_fetch_ack) begin
      fetch_req = ($urandom_range(0, 2) == 0);
      if (fetch_req) fetch_addr = AW'($urandom);
    end
    if (!data_req || e_data_ack) begin
      data_req = ($urandom_range(0, 2) == 0);
      if (data_req) begin
        data_we = 1'($urandom);
        data_addr = AW'($urandom);
        data_wdata = DW'($urandom);
      end
    end
    flush = ($urandom_range(0, 5) == 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n, fa_cnt, da_cnt;
    model_reset();
    @(negedge clock);

    // Reset state
    tick();
    tick();
    chk("reset_mem_req", mem_req, 1'b0);
    chk("reset_busy", busy, 1'b0);
    reset = 1'b1;
    tick();

    // Lone fetch, zero-wait memory
    fix_wait = 0; use_fix_rd = 1; fix_rd = 8'hA4;
    fetch_req = 1'b1; fetch_addr = 8'h05;
    wait_fetch_ack("lone_fetch", n);
    chk("lone_fetch_latency", n, 2);
    chk("lone_fetch_rdata", fetch_rdata, 8'hA4);
    fetch_req = 1'b0;
    tick();

    // Store with 2 wait states
    fix_wait = 2; fix_rd = 8'hEE;
    data_req = 1'b1; data_we = 1'b1; data_addr = 8'h10; data_wdata = 8'h3C;
    n = 0; fa_cnt = 0;
    do begin
      tick();
      if (mem_req) n++;
      if (fetch_ack) fa_cnt++;
    end while (!data_ack && n < 20);
    chk("store_memreq_cycles", n, 3);
    chk("store_no_fetch_ack", fa_cnt, 0);
    data_req = 1'b0; data_we = 1'b0;
    tick();

    // Flush one cycle before mem_ack: fetch dropped
    fix_wait = 2; fix_rd = 8'h77;
    fetch_req = 1'b1; fetch_addr = 8'h08;
    tick();                       // grant
    chk("flush_inflight_granted", mem_addr, 8'h08);
    tick();                       // first wait cycle
    flush = 1'b1; fetch_req = 1'b0;
    tick();                       // second wait cycle, flushed
    chk("flush_inflight_busy_held", busy, 1'b1);
    flush = 1'b0;
    tick();                       // mem_ack
    chk("flush_inflight_busy_fall", busy, 1'b0);
    chk("flush_inflight_rdata_kept", fetch_rdata, 8'hA4);
    chk("flush_inflight_no_ack", fetch_ack, 1'b0);
    fix_wait = 0; fix_rd = 8'h5A;
    fetch_req = 1'b1; fetch_addr = 8'h0C;
    wait_fetch_ack("refetch", n);
    chk("refetch_rdata", fetch_rdata, 8'h5A);
    fetch_req = 1'b0;
    tick();

    // Flush coincident with mem_ack
    fix_wait = 1; fix_rd = 8'h99;
    fetch_req = 1'b1; fetch_addr = 8'h30;
    tick();
    tick();
    flush = 1'b1; fetch_req = 1'b0;
    tick();
    flush = 1'b0;
    tick();
    chk("flush_coincident_no_ack", fetch_ack, 1'b0);
    chk("flush_coincident_rdata_kept", fetch_rdata, 8'h5A);

    // Flush in IDLE defers the fetch grant by one cycle
    fix_wait = 0; fix_rd = 8'h11;
    fetch_req = 1'b1; fetch_addr = 8'h40; flush = 1'b1;
    tick();
    chk("idle_flush_no_grant", mem_req, 1'b0);
    flush = 1'b0;
    tick();
    chk("idle_flush_then_grant", mem_req, 1'b1);
    wait_fetch_ack("idle_flush", n);
    chk("idle_flush_rdata", fetch_rdata, 8'h11);
    fetch_req = 1'b0;
    tick();

    // Both requesters held continuously
    use_fix_rd = 0;
    fetch_req = 1'b1; fetch_addr = 8'h50;
    data_req = 1'b1; data_we = 1'b0; data_addr = 8'h60;
    fa_cnt = 0; da_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (fetch_ack) fa_cnt++;
      if (data_ack) da_cnt++;
    end
    chk("contend_fetch_served", fa_cnt >= 5, 1'b1);
    chk("contend_data_served", da_cnt >= 5, 1'b1);

    // Randomized traffic
    fix_wait = -1;
    for (int i = 0; i < 3000; i++) begin
      random_inputs();
      tick();
    end
    fetch_req = 1'b0; data_req = 1'b0; flush = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("sb_drained", exp_q.size(), 0);

    // Reset during a DATA transaction
    reset = 1'b0;
    fix_wait = 3;
    data_req = 1'b1; data_we = 1'b0; data_addr = 8'h20;
    tick();
    reset = 1'b1;
    tick();
    chk("rst_mid_mem_req", mem_req, 1'b1);
    chk("rst_mid_mem_addr", mem_addr, 8'h20);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_mem_req_drop", mem_req, 1'b0);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_mem_addr_zero", mem_addr, 0);
    chk("rst_mid_mem_we", mem_we, 1'b0);
    chk("rst_mid_mem_wdata", mem_wdata, 0);
    chk("rst_mid_fetch_rdata", fetch_rdata, 0);
    chk("rst_mid_data_rdata", data_rdata, 0);
    chk("rst_mid_acks", {fetch_ack, data_ack}, 2'b00);
    chk("rst_mid_state", dbg_state, 2'd0);
    model_reset();
    in_txn = 0; mem_ack = 1'b0;
    data_req = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
